// File: rtl/lsu_unit.sv
// Load/store unit between the EX/MEM register and the data-memory port: one request
// in flight, lane-aligned bus cycle, extended load data, error and flush handling.
module lsu_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [2:0]              req_funct3,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [4:0]              req_rd,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  output logic                    mem_read,
  output logic                    mem_write,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ready,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic [4:0]              resp_rd,
  output logic                    resp_err,
  output logic [1:0]              resp_err_code,
  output logic                    busy
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic [OW-1:0] off;
    logic [1:0]    size;
    logic          sgn;
    logic          write;
    logic [4:0]    rd;
  } req_lat_t;

  state_t        state;
  req_lat_t      rq;
  logic          kill_q;
  logic [CW-1:0] cnt;

  // Request decode
  logic [OW-1:0] req_off, req_mask;
  logic [1:0]    req_size;
  int            req_bytes;
  logic          illegal, misaligned;
  logic [NB-1:0] be_next;
  logic [DATA_WIDTH-1:0] wdata_next;

  assign req_off    = req_addr[OW-1:0];
  assign req_size   = req_funct3[1:0];
  assign req_bytes  = 1 << req_size;
  assign req_mask   = OW'(req_bytes - 1);
  assign illegal    = (req_funct3 == 3'b111)
                   || ((DATA_WIDTH == 32) && (req_funct3 == 3'b011 || req_funct3 == 3'b110))
                   || (req_write && req_funct3[2]);
  assign misaligned = (req_off & req_mask) != '0;
  assign wdata_next = req_wdata << {req_off, 3'b000};

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign be_next[i] = (i >= int'(req_off)) && (i < int'(req_off) + req_bytes);
  end

  // Load extraction: shift selected lane down, mask to size, extend by sign of its msb
  logic [DATA_WIDTH-1:0] rd_sh, rd_mask, load_ext;
  logic                  rd_msb;

  always_comb begin
    rd_sh = mem_rdata >> {rq.off, 3'b000};
    case (rq.size)
      2'd0:    begin rd_mask = DATA_WIDTH'(8'hFF);         rd_msb = rd_sh[7];  end
      2'd1:    begin rd_mask = DATA_WIDTH'(16'hFFFF);      rd_msb = rd_sh[15]; end
      2'd2:    begin rd_mask = DATA_WIDTH'(32'hFFFF_FFFF); rd_msb = rd_sh[31]; end
      default: begin rd_mask = '1;                         rd_msb = rd_sh[DATA_WIDTH-1]; end
    endcase
    load_ext = (rd_sh & rd_mask) | ((rq.sgn && rd_msb) ? ~rd_mask : '0);
  end

  logic timeout_hit;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));

  assign req_ready = (state == IDLE) && !flush;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      rq              <= '0;
      kill_q          <= 1'b0;
      cnt             <= '0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      resp_valid      <= 1'b0;
      resp_data       <= '0;
      resp_rd         <= '0;
      resp_err        <= 1'b0;
      resp_err_code   <= 2'b00;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid && req_ready) begin
          rq     <= '{off: req_off, size: req_size, sgn: !req_funct3[2],
                      write: req_write, rd: req_rd};
          kill_q <= 1'b0;
          cnt    <= '0;
          if (illegal || misaligned) begin
            state         <= RESP;
            resp_valid    <= 1'b1;
            resp_rd       <= req_rd;
            resp_data     <= '0;
            resp_err      <= 1'b1;
            resp_err_code <= illegal ? 2'b11 : 2'b01;
          end else begin
            state           <= BUSY;
            mem_addr        <= {req_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
            mem_byte_enable <= be_next;
            mem_wdata       <= wdata_next;
            mem_read        <= !req_write;
            mem_write       <= req_write;
          end
        end
        BUSY: begin
          if (flush) kill_q <= 1'b1;
          if (mem_ready || timeout_hit) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            // A flushed request still finishes its bus cycle but reports nothing
            if (kill_q || flush) begin
              state <= IDLE;
            end else begin
              state         <= RESP;
              resp_valid    <= 1'b1;
              resp_rd       <= rq.rd;
              resp_err      <= !mem_ready;
              resp_err_code <= mem_ready ? 2'b00 : 2'b10;
              resp_data     <= (mem_ready && !rq.write) ? load_ext : '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_unit.sv
// Scoreboard bench: a 32-bit unit (short watchdog) and a 64-bit unit share stimulus fields.
module tb_lsu_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush;
  logic        a_req_valid, b_req_valid, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, cur_rdata;
  logic [4:0]  req_rd;
  int          lat;

  logic        a_req_ready, a_mem_read, a_mem_write, a_mem_ready, a_resp_valid, a_resp_err, a_busy;
  logic [31:0] a_mem_addr, a_mem_wdata, a_resp_data;
  logic [3:0]  a_be;
  logic [4:0]  a_resp_rd;
  logic [1:0]  a_resp_err_code;

  logic        b_req_ready, b_mem_read, b_mem_write, b_mem_ready, b_resp_valid, b_resp_err, b_busy;
  logic [31:0] b_mem_addr;
  logic [63:0] b_mem_wdata, b_resp_data;
  logic [7:0]  b_be;
  logic [4:0]  b_resp_rd;
  logic [1:0]  b_resp_err_code;

  lsu_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .req_rd(req_rd), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_byte_enable(a_be),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_rdata(cur_rdata[31:0]), .mem_ready(a_mem_ready),
    .resp_valid(a_resp_valid), .resp_data(a_resp_data), .resp_rd(a_resp_rd), .resp_err(a_resp_err),
    .resp_err_code(a_resp_err_code), .busy(a_busy));

  lsu_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(16)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_byte_enable(b_be),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_rdata(cur_rdata), .mem_ready(b_mem_ready),
    .resp_valid(b_resp_valid), .resp_data(b_resp_data), .resp_rd(b_resp_rd), .resp_err(b_resp_err),
    .resp_err_code(b_resp_err_code), .busy(b_busy));

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        err;
    logic [1:0]  code;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          sel;      // 0: 32-bit unit, 1: 64-bit unit
    bit          w;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          lat;
    logic [31:0] e_addr;
    logic [7:0]  e_be;
    logic [63:0] e_wdata;
    logic [63:0] e_data;
    logic [1:0]  e_code;
    int          delta;    // cycles from accept to visible resp_valid
    int          strobes;
  } vec_t;

  exp_t qa[$], qb[$];
  int   cyc = 0;
  int   n_vec = 0, n_err = 0;
  int   a_run = 0, b_run = 0, a_stot = 0, b_stot = 0;
  logic [4:0] tag = 5'd1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag_s, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag_s, got, exp);
    end
  endtask

  // Bus responders: ready after `lat` wait cycles of an active strobe
  always @(negedge clk) begin
    if (!rst_n) begin a_mem_ready = 1'b0; a_run = 0; end
    else if (a_mem_read || a_mem_write) begin
      a_mem_ready = (a_run == lat); a_run++; a_stot++;
    end else begin a_mem_ready = 1'b0; a_run = 0; end
    if (!rst_n) begin b_mem_ready = 1'b0; b_run = 0; end
    else if (b_mem_read || b_mem_write) begin
      b_mem_ready = (b_run == lat); b_run++; b_stot++;
    end else begin b_mem_ready = 1'b0; b_run = 0; end
  end

  always @(negedge clk) begin
    exp_t e;
    if (a_resp_valid) begin
      if (qa.size() == 0) chk("a_unexpected_resp", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_resp_rd", a_resp_rd, e.rd);
        chk("a_resp_data", a_resp_data, e.data);
        chk("a_resp_err", a_resp_err, e.err);
        chk("a_resp_code", a_resp_err_code, e.code);
        chk("a_resp_cycle", cyc, e.cyc);
      end
    end
    if (b_resp_valid) begin
      if (qb.size() == 0) chk("b_unexpected_resp", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_resp_rd", b_resp_rd, e.rd);
        chk("b_resp_data", b_resp_data, e.data);
        chk("b_resp_err", b_resp_err, e.err);
        chk("b_resp_code", b_resp_err_code, e.code);
        chk("b_resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drive(input vec_t v);
    req_write = v.w; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    cur_rdata = v.rdata; lat = v.lat; req_rd = tag;
    if (v.sel) b_req_valid = 1'b1; else a_req_valid = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int   n, snap, acc;
    exp_t e;
    @(negedge clk);
    drive(v);
    n = 0;
    while (!(v.sel ? b_req_ready : a_req_ready) && n < 50) begin @(negedge clk); n++; end
    if (n == 50) begin
      chk("accept_wait", 0, 1);
      a_req_valid = 1'b0; b_req_valid = 1'b0;
      return;
    end
    snap = v.sel ? b_stot : a_stot;
    @(posedge clk); #1;
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    acc = cyc;
    e.rd = tag; e.err = (v.e_code != 2'b00); e.code = v.e_code;
    e.data = v.e_data; e.cyc = acc + v.delta;
    if (v.sel) qb.push_back(e); else qa.push_back(e);
    if (v.e_code == 2'b00 || v.e_code == 2'b10) begin
      chk("mem_addr", v.sel ? b_mem_addr : a_mem_addr, v.e_addr);
      chk("byte_enable", v.sel ? b_be : {4'b0, a_be}, v.e_be);
      if (v.w) chk("mem_wdata", v.sel ? b_mem_wdata : {32'b0, a_mem_wdata}, v.e_wdata);
    end
    n = 0;
    while ((v.sel ? qb.size() : qa.size()) != 0 && n < 40) begin @(negedge clk); #1; n++; end
    if (n == 40) chk("resp_wait", 0, 1);
    @(negedge clk); #1;
    chk("strobe_cycles", (v.sel ? b_stot : a_stot) - snap, v.strobes);
    tag++;
  endtask

  localparam int NV = 20;
  vec_t vt[NV];

  initial begin
    //        sel w  f3      addr          wdata                   rdata                   lat  e_addr       be     e_wdata                 e_data                  code   dl st
    vt[0]  = '{0, 0, 3'b000, 32'h1003, 64'h0,                 64'h80FF_0000,          0,   32'h1000, 8'h08, 64'h0,                 64'hFFFF_FF80,          2'b00, 1, 1};
    vt[1]  = '{0, 1, 3'b001, 32'h2002, 64'h0000_ABCD,         64'h0,                  3,   32'h2000, 8'h0C, 64'hABCD_0000,         64'h0,                  2'b00, 4, 4};
    vt[2]  = '{0, 0, 3'b010, 32'h3002, 64'h0,                 64'h0,                  0,   32'h0,    8'h00, 64'h0,                 64'h0,                  2'b01, 0, 0};
    vt[3]  = '{0, 0, 3'b111, 32'h3000, 64'h0,                 64'h0,                  0,   32'h0,    8'h00, 64'h0,                 64'h0,                  2'b11, 0, 0};
    vt[4]  = '{0, 0, 3'b011, 32'h3000, 64'h0,                 64'h0,                  0,   32'h0,    8'h00, 64'h0,                 64'h0,                  2'b11, 0, 0};
    vt[5]  = '{0, 1, 3'b100, 32'h3000, 64'h11,                64'h0,                  0,   32'h0,    8'h00, 64'h0,                 64'h0,                  2'b11, 0, 0};
    vt[6]  = '{0, 0, 3'b010, 32'h4000, 64'h0,                 64'h5555_5555,          100, 32'h4000, 8'h0F, 64'h0,                 64'h0,                  2'b10, 4, 4};
    vt[7]  = '{0, 0, 3'b010, 32'h4004, 64'h0,                 64'h1234_5678,          3,   32'h4004, 8'h0F, 64'h0,                 64'h1234_5678,          2'b00, 4, 4};
    vt[8]  = '{0, 0, 3'b101, 32'h1002, 64'h0,                 64'hF00D_0000,          0,   32'h1000, 8'h0C, 64'h0,                 64'h0000_F00D,          2'b00, 1, 1};
    vt[9]  = '{0, 0, 3'b001, 32'h1002, 64'h0,                 64'hF00D_0000,          1,   32'h1000, 8'h0C, 64'h0,                 64'hFFFF_F00D,          2'b00, 2, 2};
    vt[10] = '{0, 0, 3'b100, 32'h1001, 64'h0,                 64'h0000_9A00,          0,   32'h1000, 8'h02, 64'h0,                 64'h0000_009A,          2'b00, 1, 1};
    vt[11] = '{0, 1, 3'b000, 32'h5001, 64'h77,                64'h0,                  1,   32'h5000, 8'h02, 64'h7700,              64'h0,                  2'b00, 2, 2};
    vt[12] = '{0, 1, 3'b010, 32'h5000, 64'hDEAD_BEEF,         64'h0,                  0,   32'h5000, 8'h0F, 64'hDEAD_BEEF,         64'h0,                  2'b00, 1, 1};
    vt[13] = '{1, 0, 3'b110, 32'h14,   64'h0,                 64'h8765_4321_0000_0000, 0,  32'h10,   8'hF0, 64'h0,                 64'h0000_0000_8765_4321, 2'b00, 1, 1};
    vt[14] = '{1, 0, 3'b010, 32'h14,   64'h0,                 64'h8765_4321_0000_0000, 2,  32'h10,   8'hF0, 64'h0,                 64'hFFFF_FFFF_8765_4321, 2'b00, 3, 3};
    vt[15] = '{1, 0, 3'b011, 32'h18,   64'h0,                 64'h0123_4567_89AB_CDEF, 0,  32'h18,   8'hFF, 64'h0,                 64'h0123_4567_89AB_CDEF, 2'b00, 1, 1};
    vt[16] = '{1, 1, 3'b001, 32'h1E,   64'hBEEF,              64'h0,                  0,   32'h18,   8'hC0, 64'hBEEF_0000_0000_0000, 64'h0,                 2'b00, 1, 1};
    vt[17] = '{1, 0, 3'b000, 32'h19,   64'h0,                 64'h0000_0000_0000_7F00, 0,  32'h18,   8'h02, 64'h0,                 64'h0000_0000_0000_007F, 2'b00, 1, 1};
    vt[18] = '{1, 0, 3'b010, 32'h16,   64'h0,                 64'h0,                  0,   32'h0,    8'h00, 64'h0,                 64'h0,                  2'b01, 0, 0};
    vt[19] = '{1, 1, 3'b110, 32'h10,   64'h0,                 64'h0,                  0,   32'h0,    8'h00, 64'h0,                 64'h0,                  2'b11, 0, 0};
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int snap;
    rst_n = 1'b0; flush = 1'b0; a_req_valid = 1'b0; b_req_valid = 1'b0;
    req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
    cur_rdata = '0; lat = 0;
    #1;
    chk("rst_a_req_ready", a_req_ready, 1);
    chk("rst_a_mem_read", a_mem_read, 0);
    chk("rst_a_resp_valid", a_resp_valid, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_b_req_ready", b_req_ready, 1);
    chk("rst_b_mem_write", b_mem_write, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vt[i]);

    // Flush one cycle into BUSY: bus cycle completes, no response
    @(negedge clk);
    drive('{0, 0, 3'b010, 32'h6000, 64'h0, 64'hCAFE_F00D, 3, 32'h0, 8'h0, 64'h0, 64'h0, 2'b00, 0, 0});
    snap = a_stot;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_busy", a_busy, 1);
    chk("flush_req_ready", a_req_ready, 0);
    chk("flush_mem_read", a_mem_read, 1);
    @(negedge clk);
    flush = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("flush_strobes", a_stot - snap, 4);
    chk("flush_idle_busy", a_busy, 0);
    chk("flush_idle_ready", a_req_ready, 1);

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    drive('{0, 0, 3'b010, 32'h6000, 64'h0, 64'h0, 0, 32'h0, 8'h0, 64'h0, 64'h0, 2'b00, 0, 0});
    flush = 1'b1;
    #1;
    chk("idle_flush_ready", a_req_ready, 0);
    @(posedge clk); #1;
    chk("idle_flush_busy", a_busy, 0);
    a_req_valid = 1'b0; flush = 1'b0;

    // Async reset mid-transaction drops strobes immediately
    @(negedge clk);
    drive('{0, 0, 3'b010, 32'h7000, 64'h0, 64'h0, 100, 32'h0, 8'h0, 64'h0, 64'h0, 2'b00, 0, 0});
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    chk("pre_rst_mem_read", a_mem_read, 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_read", a_mem_read, 0);
    chk("mid_rst_busy", a_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
